// File: rtl/ritc_bit_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ritc_bit_control_sequencer
// Purpose  : Queues per-bit delay-load / bitslip commands in a small FIFO and
//            issues them one at a time to a downstream loader. For each
//            command it waits for the loader's busy handshake and reports
//            completion, a missing busy response, or a busy timeout.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o command handshake (transfer when both high)
//   cmd_bit_i/chan_i/delay_i/bitslip_i  command fields
//   bit_addr_o/chan_addr_o/delay_o      registered fields to the loader
//   load_o / bitslip_o      one-cycle strobes to the loader
//   loader_busy_i           loader busy flag
//   done_o                  one-cycle completion pulse
//   pending_o               queued + in-flight command count
//   err_o                   sticky errors: [0] bad channel, [1] loader timeout
//   err_clr_i               clears err_o (wins over a same-cycle set)
// ============================================================================
module ritc_bit_control_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 200
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [3:0] cmd_bit_i,
    input  logic [2:0] cmd_chan_i,
    input  logic [4:0] cmd_delay_i,
    input  logic       cmd_bitslip_i,
    output logic [3:0] bit_addr_o,
    output logic [2:0] chan_addr_o,
    output logic [4:0] delay_o,
    output logic       load_o,
    output logic       bitslip_o,
    input  logic       loader_busy_i,
    output logic       done_o,
    output logic [4:0] pending_o,
    output logic [1:0] err_o,
    input  logic       err_clr_i
);

    localparam int               c_AW       = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0]    c_DEPTH    = FIFO_DEPTH[c_AW:0];
    localparam logic [c_AW:0]    c_CNT_ONE  = 1;
    localparam logic [c_AW-1:0]  c_PTR_ONE  = 1;
    localparam logic [7:0]       c_TO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [2:0]       c_MAX_CHAN = 3'd2;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    // ---------------------------------------------------------------- FIFO
    // Entry layout: {bitslip, delay[4:0], chan[2:0], bit[3:0]}
    logic [12:0]     r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_AW:0]   r_count;
    logic            r_rdy_en;   // holds ready low until the first edge out of reset

    logic            w_full;
    logic            w_accept;
    logic            w_push;
    logic            w_reject;
    logic            w_pop;
    logic [12:0]     w_head;

    assign w_full      = (r_count == c_DEPTH);
    assign cmd_ready_o = r_rdy_en & ~w_full;
    assign w_accept    = cmd_valid_i & cmd_ready_o;
    // Out-of-range channels still complete the handshake but are dropped.
    assign w_push      = w_accept & (cmd_chan_i <= c_MAX_CHAN);
    assign w_reject    = w_accept & (cmd_chan_i >  c_MAX_CHAN);
    assign w_head      = r_mem[r_rptr];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= {cmd_bitslip_i, cmd_delay_i, cmd_chan_i, cmd_bit_i};
        end
    end

    // ----------------------------------------------------------------- FSM
    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic       w_load_nxt;
    logic       w_slip_nxt;
    logic       w_done_nxt;
    logic       w_err_to;

    logic [3:0] r_bit;
    logic [2:0] r_chan;
    logic [4:0] r_delay;
    logic       r_load;
    logic       r_slip;
    logic       r_done;
    logic [1:0] r_err;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        w_load_nxt  = 1'b0;
        w_slip_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_to    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((r_count != '0) && !loader_busy_i) begin
                    w_pop       = 1'b1;
                    w_load_nxt  = ~w_head[12];
                    w_slip_nxt  = w_head[12];
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_cnt_nxt   = 8'd0;
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // The loader gets two cycles after the strobe to raise busy.
                if (loader_busy_i) begin
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_cnt == 8'd1) begin
                    w_err_to    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_WAIT_DONE: begin
                if (!loader_busy_i) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == c_TO_LAST) begin
                    w_err_to    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= 8'd0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_rdy_en <= 1'b0;
            r_bit    <= 4'd0;
            r_chan   <= 3'd0;
            r_delay  <= 5'd0;
            r_load   <= 1'b0;
            r_slip   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 2'b00;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rdy_en <= 1'b1;
            r_load   <= w_load_nxt;
            r_slip   <= w_slip_nxt;
            r_done   <= w_done_nxt;
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr  <= r_rptr + c_PTR_ONE;
                // Fields stay put until the next pop, keeping them stable
                // for the whole loader transaction.
                r_bit   <= w_head[3:0];
                r_chan  <= w_head[6:4];
                r_delay <= w_head[11:7];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (err_clr_i) begin
                r_err <= 2'b00;
            end else begin
                r_err <= r_err | {w_err_to, w_reject};
            end
        end
    end

    assign bit_addr_o  = r_bit;
    assign chan_addr_o = r_chan;
    assign delay_o     = r_delay;
    assign load_o      = r_load;
    assign bitslip_o   = r_slip;
    assign done_o      = r_done;
    assign err_o       = r_err;
    // The in-flight command has already left the FIFO, so add it back.
    assign pending_o   = 5'(r_count) + {4'd0, (r_state != S_IDLE)};

endmodule
`default_nettype wire

// File: tb/tb_ritc_bit_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ritc_bit_control_sequencer
// Purpose  : Self-checking bench for ritc_bit_control_sequencer. Accepted
//            commands are pushed to an expected-strobe queue; a monitor pops
//            and compares on every strobe. A loader model answers strobes.
// Revision : 1.0  initial release
// ============================================================================
module tb_ritc_bit_control_sequencer;

    localparam int c_TIMEOUT = 200;

    typedef struct packed {
        logic [3:0] b;
        logic [2:0] c;
        logic [4:0] d;
        logic       s;
    } cmd_t;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_bit;
    logic [2:0] cmd_chan;
    logic [4:0] cmd_delay;
    logic       cmd_bitslip;
    logic [3:0] bit_addr;
    logic [2:0] chan_addr;
    logic [4:0] delay;
    logic       load;
    logic       bitslip;
    logic       loader_busy;
    logic       done;
    logic [4:0] pending;
    logic [1:0] err;
    logic       err_clr;

    ritc_bit_control_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(c_TIMEOUT)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_bit_i    (cmd_bit),
        .cmd_chan_i   (cmd_chan),
        .cmd_delay_i  (cmd_delay),
        .cmd_bitslip_i(cmd_bitslip),
        .bit_addr_o   (bit_addr),
        .chan_addr_o  (chan_addr),
        .delay_o      (delay),
        .load_o       (load),
        .bitslip_o    (bitslip),
        .loader_busy_i(loader_busy),
        .done_o       (done),
        .pending_o    (pending),
        .err_o        (err),
        .err_clr_i    (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_strobe = 0;
    int   n_done   = 0;
    cmd_t exp_q[$];
    cmd_t last_issued;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------- loader model
    // mode 0: busy for ld_len cycles (or random 2..20), 1: never busy,
    // 2: busy forever. ld_hold forces busy regardless of mode.
    int ld_mode = 0;
    int ld_len  = 5;
    bit ld_rand = 0;
    bit ld_hold = 0;
    int ld_cnt  = 0;
    bit ld_stuck = 0;

    initial begin
        loader_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ld_cnt   = 0;
                ld_stuck = 0;
            end else if (load || bitslip) begin
                if (ld_mode == 0) ld_cnt = ld_rand ? int'($urandom_range(2, 20)) : ld_len;
                else if (ld_mode == 2) ld_stuck = 1;
            end else if (ld_cnt > 0) begin
                ld_cnt--;
            end
            if (ld_mode != 2) ld_stuck = 0;
            loader_busy = ld_hold | ld_stuck | (ld_cnt > 0);
        end
    end

    // ------------------------------------------------------------ monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (load && bitslip) chk("both_strobes", 1, 0);
                if (load || bitslip) begin
                    n_strobe++;
                    chk("strobe_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                    if (exp_q.size() > 0) begin
                        last_issued = exp_q.pop_front();
                        chk("strobe_fields",
                            {bit_addr, chan_addr, delay, bitslip, load},
                            {last_issued.b, last_issued.c, last_issued.d,
                             last_issued.s, ~last_issued.s});
                    end
                end
                if (done) begin
                    n_done++;
                    chk("done_fields_stable", {bit_addr, chan_addr, delay},
                        {last_issued.b, last_issued.c, last_issued.d});
                end
            end
        end
    end

    // ------------------------------------------------------ stimulus tasks
    // Called at a negedge; returns one negedge after the transfer edge.
    task automatic send(input logic [3:0] b, input logic [2:0] c,
                        input logic [4:0] d, input logic s);
        int   k;
        cmd_t e;
        k = 0;
        cmd_bit = b; cmd_chan = c; cmd_delay = d; cmd_bitslip = s;
        cmd_valid = 1'b1;
        while (!cmd_ready && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 1000) begin
            chk("send_ready_timeout", 0, 1);
        end else if (c <= 3'd2) begin
            e.b = b; e.c = c; e.d = d; e.s = s;
            exp_q.push_back(e);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((pending != 0 || loader_busy) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk("wait_idle_bound", (k < 5000) ? 1 : 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_strobe(input string nm);
        int k;
        k = 0;
        while (!(load || bitslip) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk(nm, (k < 20) ? 1 : 0, 1);
    endtask

    task automatic chk_zero_outs(input string nm);
        chk(nm, {load, bitslip, done, err, pending, bit_addr, chan_addr, delay, cmd_ready}, 0);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    // --------------------------------------------------------------- main
    initial begin
        int   d0;
        int   s0;
        int   n_ok;
        bit   any_rej;
        logic [2:0] rc;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_bit = '0; cmd_chan = '0;
        cmd_delay = '0; cmd_bitslip = 1'b0; err_clr = 1'b0;

        // Reset state and ready rising on the first edge after release
        repeat (3) @(negedge clk);
        chk_zero_outs("reset_state");
        rst_n = 1'b1;
        #1 chk("ready_before_first_edge", cmd_ready, 0);
        @(negedge clk);
        chk("ready_after_first_edge", cmd_ready, 1);
        chk("pending_idle", pending, 0);

        // Single load, loader busy 71 cycles
        ld_mode = 0; ld_len = 71; d0 = n_done; s0 = n_strobe;
        send(4'd5, 3'd1, 5'h13, 1'b0);
        chk("single_pending_1", pending, 1);
        wait_idle();
        chk("single_done_count", n_done - d0, 1);
        chk("single_strobe_count", n_strobe - s0, 1);
        chk("single_pending_0", pending, 0);

        // Four commands while loader busy: FIFO fills, 3rd is bitslip
        ld_hold = 1; ld_len = 6;
        repeat (2) @(negedge clk);
        d0 = n_done; s0 = n_strobe;
        send(4'd13, 3'd0, 5'h1F, 1'b0);
        send(4'd15, 3'd1, 5'h00, 1'b0);
        send(4'd0,  3'd2, 5'h0A, 1'b1);
        send(4'd7,  3'd1, 5'h15, 1'b0);
        chk("full_ready_low", cmd_ready, 0);
        chk("full_pending_4", pending, 4);
        ld_hold = 0;
        wait_idle();
        chk("four_done_count", n_done - d0, 4);
        chk("four_strobe_count", n_strobe - s0, 4);

        // Rejected channel
        s0 = n_strobe;
        send(4'd3, 3'd3, 5'h04, 1'b0);
        repeat (4) @(negedge clk);
        chk("reject_err", err, 2'b01);
        chk("reject_pending", pending, 0);
        chk("reject_no_strobe", n_strobe - s0, 0);
        clear_err();
        chk("err_cleared", err, 2'b00);
        // Clear in the same cycle as a reject wins
        err_clr = 1'b1;
        send(4'd3, 3'd7, 5'h04, 1'b0);
        err_clr = 1'b0;
        chk("clear_wins_over_set", err, 2'b00);

        // Loader never raises busy: err[1] three cycles after the strobe
        ld_mode = 1; d0 = n_done;
        send(4'd9, 3'd2, 5'h07, 1'b0);
        wait_strobe("never_strobe_seen");
        @(negedge clk); chk("never_err_plus1", err, 2'b00);
        @(negedge clk); chk("never_err_plus2", err, 2'b00);
        @(negedge clk); chk("never_err_plus3", err, 2'b10);
        chk("never_pending", pending, 0);
        chk("never_no_done", n_done - d0, 0);
        clear_err();
        ld_mode = 0; ld_len = 4; d0 = n_done;
        send(4'd2, 3'd0, 5'h11, 1'b1);
        wait_idle();
        chk("after_never_done", n_done - d0, 1);
        chk("after_never_err", err, 2'b00);

        // Loader stuck busy: one cycle to see busy, then TIMEOUT cycles waiting
        ld_mode = 2; d0 = n_done;
        send(4'd11, 3'd1, 5'h1C, 1'b0);
        wait_strobe("stuck_strobe_seen");
        for (int i = 1; i <= c_TIMEOUT + 2; i++) begin
            @(negedge clk);
            if (i == c_TIMEOUT + 1) chk("stuck_err_before", err, 2'b00);
            if (i == c_TIMEOUT + 2) chk("stuck_err_after", err, 2'b10);
        end
        chk("stuck_no_done", n_done - d0, 0);
        chk("stuck_pending", pending, 0);
        ld_mode = 0;
        repeat (2) @(negedge clk);
        clear_err();

        // Reset in WAIT_DONE with two commands queued
        ld_len = 50;
        send(4'd1, 3'd0, 5'h01, 1'b0);
        send(4'd2, 3'd1, 5'h02, 1'b1);
        send(4'd3, 3'd2, 5'h03, 1'b0);
        repeat (10) @(negedge clk);
        chk("pre_reset_pending", pending, 3);
        #2 rst_n = 1'b0;
        #1 chk_zero_outs("async_reset_outputs");
        exp_q.delete();
        s0 = n_strobe; d0 = n_done;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("post_reset_no_strobe", n_strobe - s0, 0);
        chk("post_reset_no_done", n_done - d0, 0);
        chk("post_reset_pending", pending, 0);
        chk("post_reset_ready", cmd_ready, 1);

        // Randomized traffic
        ld_rand = 1; d0 = n_done; n_ok = 0; any_rej = 0;
        for (int i = 0; i < 30; i++) begin
            rc = 3'($urandom_range(0, 3));
            if (rc > 3'd2) any_rej = 1; else n_ok++;
            send(4'($urandom_range(0, 15)), rc, 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();
        chk("rand_done_count", n_done - d0, n_ok);
        chk("rand_err", err, {1'b0, any_rej});
        chk("rand_pending", pending, 0);
        chk("exp_queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
